// File: rtl/soc_mnt.sv
// Simulation-control monitor: snoops AHB-Lite writes to the terminate register and
// the retire strobe, raising sticky pass/fail/hang/timeout flags and console pulses.
module soc_mnt #(
   parameter logic [31:0] TERM_ADDR  = 32'h6000_fff8,
   parameter int unsigned LAST_CYCLE = 5000,
   parameter int unsigned MAX_CYCLES = 70_000_000
) (
   input  logic        i_pad_clk,
   input  logic        i_pad_rst,
   input  logic [1:0]  biu_pad_htrans,
   input  logic [31:0] biu_pad_haddr,
   input  logic        biu_pad_hwrite,
   input  logic [31:0] biu_pad_hwdata,
   input  logic        biu_pad_retire,
   output logic        mon_char_vld,
   output logic [7:0]  mon_char,
   output logic        mon_pass,
   output logic        mon_fail,
   output logic        mon_hang,
   output logic        mon_timeout,
   output logic        mon_done,
   output logic [31:0] mon_cycle_cnt
);

   localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
   localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
   localparam logic [31:0] LAST_C        = 32'(LAST_CYCLE);
   localparam logic [31:0] MAX_C         = 32'(MAX_CYCLES);

   logic [1:0]  htrans_q, htrans_d;
   logic [31:0] haddr_q, haddr_d;
   logic        hwrite_q, hwrite_d;
   logic        char_vld_q, char_vld_d;
   logic [7:0]  char_q, char_d;
   logic        pass_q, pass_d;
   logic        fail_q, fail_d;
   logic        hang_q, hang_d;
   logic        timeout_q, timeout_d;
   logic [31:0] cyc_q, cyc_d;
   logic [31:0] per_q, per_d;
   logic [31:0] ret_q, ret_d;

   logic hit, pass_ev, fail_ev, hang_ev, timeout_ev, done;

   assign done = pass_q | fail_q | hang_q | timeout_q;

   always_comb begin
      htrans_d   = biu_pad_htrans;
      haddr_d    = biu_pad_haddr;
      hwrite_d   = biu_pad_hwrite;
      cyc_d      = cyc_q + 32'd1;
      per_d      = per_q + 32'd1;
      ret_d      = ret_q;
      char_vld_d = 1'b0;
      char_d     = char_q;
      pass_d     = pass_q;
      fail_d     = fail_q;
      hang_d     = hang_q;
      timeout_d  = timeout_q;

      // Decode uses the captured address phase with the live data phase.
      hit        = (htrans_q == HTRANS_NONSEQ) && (haddr_q == TERM_ADDR) && hwrite_q;
      pass_ev    = hit && ((biu_pad_hwdata == 32'h0000_0fff) || (biu_pad_hwdata == 32'hffff_0000));
      fail_ev    = hit && ((biu_pad_hwdata == 32'h0000_0eee) || (biu_pad_hwdata == 32'heeee_0000));
      hang_ev    = (per_q == LAST_C) && (ret_q == 32'd0);
      timeout_ev = (cyc_q == MAX_C);

      // A retire landing on the check cycle is dropped with the cleared count.
      if (per_q == LAST_C) begin
         per_d = 32'd1;
         ret_d = 32'd0;
      end else if (biu_pad_retire) begin
         ret_d = ret_q + 32'd1;
      end

      if (!done) begin
         if (pass_ev) begin
            pass_d = 1'b1;
         end else if (fail_ev) begin
            fail_d = 1'b1;
         end else if (hang_ev) begin
            hang_d = 1'b1;
         end else if (timeout_ev) begin
            timeout_d = 1'b1;
         end
         if (hit && !pass_ev && !fail_ev) begin
            char_vld_d = 1'b1;
            char_d     = biu_pad_hwdata[7:0];
         end
      end
   end

   always_ff @(posedge i_pad_clk) begin
      if (i_pad_rst) begin
         htrans_q   <= HTRANS_IDLE;
         haddr_q    <= 32'd0;
         hwrite_q   <= 1'b0;
         char_vld_q <= 1'b0;
         char_q     <= 8'd0;
         pass_q     <= 1'b0;
         fail_q     <= 1'b0;
         hang_q     <= 1'b0;
         timeout_q  <= 1'b0;
         cyc_q      <= 32'd1;
         per_q      <= 32'd1;
         ret_q      <= 32'd0;
      end else begin
         htrans_q   <= htrans_d;
         haddr_q    <= haddr_d;
         hwrite_q   <= hwrite_d;
         char_vld_q <= char_vld_d;
         char_q     <= char_d;
         pass_q     <= pass_d;
         fail_q     <= fail_d;
         hang_q     <= hang_d;
         timeout_q  <= timeout_d;
         cyc_q      <= cyc_d;
         per_q      <= per_d;
         ret_q      <= ret_d;
      end
   end

   assign mon_char_vld  = char_vld_q;
   assign mon_char      = char_q;
   assign mon_pass      = pass_q;
   assign mon_fail      = fail_q;
   assign mon_hang      = hang_q;
   assign mon_timeout   = timeout_q;
   assign mon_done      = done;
   assign mon_cycle_cnt = cyc_q;

endmodule

// File: tb/tb_soc_mnt.sv
// Bench for soc_mnt: console characters via an expected queue, plus flag, priority,
// watchdog, timeout and reset checks with small window parameters.
module tb_soc_mnt;
  localparam logic [31:0] TERM = 32'h6000_fff8;
  localparam int unsigned LAST = 20;
  localparam int unsigned MAXC = 300;
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] BUSY = 2'b01;
  localparam logic [1:0] NSEQ = 2'b10;
  localparam logic [1:0] SEQ  = 2'b11;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  htrans = IDLE;
  logic [31:0] haddr = '0;
  logic        hwrite = 1'b0;
  logic [31:0] hwdata = '0;
  logic        retire = 1'b0;
  logic        char_vld, pass, fail, hang, timeout, done;
  logic [7:0]  chr;
  logic [31:0] cyc_cnt;

  always #5 clk = ~clk;

  soc_mnt #(.TERM_ADDR(TERM), .LAST_CYCLE(LAST), .MAX_CYCLES(MAXC)) dut (
    .i_pad_clk(clk), .i_pad_rst(rst),
    .biu_pad_htrans(htrans), .biu_pad_haddr(haddr), .biu_pad_hwrite(hwrite),
    .biu_pad_hwdata(hwdata), .biu_pad_retire(retire),
    .mon_char_vld(char_vld), .mon_char(chr), .mon_pass(pass), .mon_fail(fail),
    .mon_hang(hang), .mon_timeout(timeout), .mon_done(done), .mon_cycle_cnt(cyc_cnt)
  );

  // Reference cycle count: 1 after a reset edge, +1 on every other edge.
  logic [31:0] exp_cyc = 32'd1;
  always @(posedge clk) exp_cyc <= rst ? 32'd1 : exp_cyc + 32'd1;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && char_vld === 1'b1) begin
      if (exp_q.size() == 0) check("char_unexpected", {24'd0, chr}, 32'hffff_ffff);
      else check("char", {24'd0, chr}, {24'd0, exp_q.pop_front()});
    end
  end

  // ---------------- driver tasks ----------------
  // One bus cycle: new address phase plus data for the previous transfer.
  task automatic ahb_cycle(input logic [1:0] t, input logic [31:0] a, input logic w,
                           input logic [31:0] d);
    htrans = t; haddr = a; hwrite = w; hwdata = d;
    @(posedge clk); #1;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) ahb_cycle(IDLE, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic tick_until(input logic [31:0] c);
    while (exp_cyc != c) tick(1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic single_wr(input logic [1:0] t, input logic [31:0] a, input logic w,
                           input logic [31:0] d);
    ahb_cycle(t, a, w, 32'd0);
    ahb_cycle(IDLE, 32'd0, 1'b0, d);
  endtask

  task automatic check_flags(input string tag, input logic [3:0] exp_pfht);
    check(tag, {27'd0, done, pass, fail, hang, timeout}, {27'd0, |exp_pfht, exp_pfht});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    @(posedge clk); #1;
    do_reset();
    check_flags("reset_flags", 4'b0000);
    check("reset_cyc", cyc_cnt, 32'd1);
    check("reset_char", {23'd0, char_vld, chr}, 32'd0);

    // Back-to-back console characters.
    retire = 1'b1;
    ahb_cycle(NSEQ, TERM, 1'b1, 32'd0);
    ahb_cycle(NSEQ, TERM, 1'b1, 32'h48);
    exp_q.push_back(8'h48);
    check("vld_first", {31'd0, char_vld}, 32'd1);
    ahb_cycle(IDLE, 32'd0, 1'b0, 32'h69);
    exp_q.push_back(8'h69);
    check("vld_second", {31'd0, char_vld}, 32'd1);
    tick(1);
    check("vld_idle", {31'd0, char_vld}, 32'd0);
    check_flags("char_noflags", 4'b0000);
    check("char_cyc", cyc_cnt, exp_cyc);

    // Pass, then later writes are frozen out.
    ahb_cycle(NSEQ, TERM, 1'b1, 32'd0);
    check("pass_before", {31'd0, pass}, 32'd0);
    ahb_cycle(IDLE, 32'd0, 1'b0, 32'h0000_0fff);
    check_flags("pass_set", 4'b1000);
    single_wr(NSEQ, TERM, 1'b1, 32'h0000_0eee);
    single_wr(NSEQ, TERM, 1'b1, 32'h41);
    tick(2);
    check_flags("pass_sticky", 4'b1000);

    // Reset mid-run clears everything after one edge.
    rst = 1'b1;
    tick(1);
    check_flags("midrst_flags", 4'b0000);
    check("midrst_cyc", cyc_cnt, 32'd1);
    rst = 1'b0;

    // Non-hits: SEQ, BUSY, read, neighbour address.
    single_wr(SEQ, TERM, 1'b1, 32'heeee_0000);
    single_wr(BUSY, TERM, 1'b1, 32'heeee_0000);
    single_wr(NSEQ, TERM, 1'b0, 32'heeee_0000);
    single_wr(NSEQ, 32'h6000_fffc, 1'b1, 32'heeee_0000);
    tick(1);
    check_flags("nohit_flags", 4'b0000);
    single_wr(NSEQ, TERM, 1'b1, 32'heeee_0000);
    check_flags("fail_set", 4'b0100);

    do_reset();
    single_wr(NSEQ, TERM, 1'b1, 32'hffff_0000);
    check_flags("pass_alt", 4'b1000);
    do_reset();
    single_wr(NSEQ, TERM, 1'b1, 32'h0000_0eee);
    check_flags("fail_alt", 4'b0100);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      logic [7:0] c;
      c = 8'($urandom_range(8'h20, 8'h7e));
      single_wr(NSEQ, TERM, 1'b1, {24'h0000_00, c});
      exp_q.push_back(c);
    end
    tick(1);
    check("char_drain", exp_q.size(), 32'd0);

    // Hang with no retirement: set at the edge leaving cycle LAST.
    retire = 1'b0;
    do_reset();
    tick_until(LAST);
    check("hang_early", {31'd0, hang}, 32'd0);
    tick(1);
    check_flags("hang_set", 4'b0010);

    // Retire in LAST-1 keeps period alive; retire in LAST is dropped.
    do_reset();
    tick_until(LAST - 1);
    retire = 1'b1;
    tick(2);
    retire = 1'b0;
    check("hang_avoided", {31'd0, hang}, 32'd0);
    tick_until(2 * LAST);
    check("hang_p2_early", {31'd0, hang}, 32'd0);
    tick(1);
    check_flags("hang_p2", 4'b0010);

    // Fail and hang on the same edge: fail wins.
    do_reset();
    tick_until(LAST - 1);
    ahb_cycle(NSEQ, TERM, 1'b1, 32'd0);
    ahb_cycle(IDLE, 32'd0, 1'b0, 32'heeee_0000);
    check_flags("prio_fail_hang", 4'b0100);

    // Timeout with retire held high.
    retire = 1'b1;
    do_reset();
    tick_until(MAXC);
    check("timeout_early", {31'd0, timeout}, 32'd0);
    tick(1);
    check_flags("timeout_set", 4'b0001);
    check("timeout_cyc", cyc_cnt, exp_cyc);

    // Pass on the timeout edge: only pass.
    do_reset();
    tick_until(MAXC - 1);
    ahb_cycle(NSEQ, TERM, 1'b1, 32'd0);
    ahb_cycle(IDLE, 32'd0, 1'b0, 32'h0000_0fff);
    tick(3);
    check_flags("prio_pass_to", 4'b1000);

    tick(2);
    check("final_drain", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
